spi_file_loader: RTL
====================

# spi_file_loader

Parametrised loader that fetches a file from the ESP32 over the SPI "fread" request/response stream in fixed-size chunks, packs the received bytes little-endian into DATA_W-bit words, and stores them in an internal RAM. Once the whole file is in, the RAM is exposed through a registered read port. It sits between the SPI fread request/response FIFOs and the consumer logic, such as a video or sample player. It generalises the single-purpose byte loader with:
- configurable file length, chunk size and word width;
- a runtime base offset;
- explicit start and restart;
- internal byte counting for chunk boundaries.

## Interface
Parameters:
- FILE_LEN, 12288: bytes to load. Must be a multiple of DATA_W/8 and ≥ 1 word.
- CHUNK_LEN, 2048: bytes per fread request. Must be a multiple of DATA_W/8. The last chunk may be short.
- DATA_W, 16: RAM word width, one of 8/16/32.
- DEPTH (derived): FILE_LEN/(DATA_W/8) words.
- ADDR_W (derived): $clog2(DEPTH).

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE or DONE; ignored while loading.
- base_offset  in  32  file byte offset of the first chunk; sampled on an accepted start.
- req_valid  out  1  fread request valid.
- req_ready  in  1  fread request accepted.
- req_offset  out  32  byte offset of the requested chunk; stable while req_valid.
- resp_data  in  8  response byte.
- resp_valid  in  1  response byte strobe; no backpressure.
- loading  out  1  high in REQ or RECV.
- done  out  1  high in DONE.
- rd_addr  in  ADDR_W  word read address.
- rd_data  out  DATA_W  registered read data.

## Operation
- States:
  - IDLE: wait for start.
  - REQ: issue the request for the current chunk.
  - RECV: collect bytes for the current chunk.
  - DONE: file loaded; read port live.
- Reset (async, rst_n low): state IDLE. req_valid=0, req_offset=0, loading=0, done=0, rd_data=0. All byte, word and chunk counters cleared. RAM contents undefined.
- IDLE/DONE + start:
  - base latched;
  - chunk index, total byte count and word address cleared;
  - done drops;
  - go to REQ.
- REQ:
  - req_valid=1 and req_offset = base + chunk_idx*CHUNK_LEN (32-bit, wraps modulo 2^32).
  - Held until req_valid & req_ready, then go to RECV.
  - resp_valid in REQ is ignored.
- RECV, each resp_valid:
  - byte i of the current word goes to lane i (bits 8i+7:8i), first byte in the LSBs;
  - chunk byte count and total byte count increment;
  - on the last byte of a word, the word is written at the word address, which then increments.
- RECV exit:
  - When total == FILE_LEN, go to DONE. A partial final chunk ends early.
  - Otherwise, when chunk count == CHUNK_LEN, increment chunk_idx, clear the chunk count and go to REQ.
- resp_valid in IDLE or DONE is ignored; no RAM write.
- A start pulse during REQ or RECV is ignored.
- DONE: rd_data <= RAM[rd_addr] every cycle. rd_addr ≥ DEPTH gives 0.
- Outside DONE: rd_data holds its last value (0 after reset).

## Timing
- start at cycle N → req_valid=1 from N+1.
- Handshake at cycle M (req_valid & req_ready) → req_valid=0 at M+1. At least one idle cycle separates consecutive requests.
- A word is written at the edge that captures its last byte. It is readable in DONE, with rd_data one cycle after rd_addr.
- Final byte at cycle K → done=1 and loading=0 from K+1.
- resp_valid may be asserted every cycle; no throughput loss.
- Reset asserted mid-load: immediate return to IDLE, outputs at reset values. The next start reloads from chunk 0.

## Test plan
- Default parameters, base 0, req_ready always high, bytes 0x00..0xFF repeating:
  - exactly 6 requests with offsets 0x0000, 0x0800 … 0x2800;
  - done one cycle after byte 12287;
  - rd_addr=0 → 0x0100 and rd_addr=1 → 0x0302 one cycle later.
- FILE_LEN=5000, CHUNK_LEN=2048, DATA_W=32, base 0x10000:
  - offsets 0x10000, 0x10800, 0x11000;
  - the last chunk ends after 904 bytes;
  - word 1249 holds bytes 4996..4999.
- req_ready held low 20 cycles: req_valid and req_offset stable throughout; bytes injected during REQ are not stored (RAM word 0 is the post-handshake data).
- Start pulse mid-RECV: no effect. After done, a second start with base 0x4000 reloads: done drops, first offset 0x4000, new data is readable.
- rst_n pulsed low mid-chunk 3: req_valid, loading and done are 0 immediately. A new start issues offset base+0.
- In DONE, rd_addr=DEPTH → rd_data=0; resp_valid bursts do not change any RAM word.

Source files
------------

// File: rtl/spi_file_loader.sv
// Fetches a file over the SPI fread request/response stream in CHUNK_LEN-byte chunks,
// packs bytes little-endian into DATA_W-bit words in an internal RAM, then serves reads.
module spi_file_loader #(
  parameter int FILE_LEN  = 12288,
  parameter int CHUNK_LEN = 2048,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = FILE_LEN / (DATA_W / 8),
  parameter int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       base_offset,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [31:0]       req_offset,
  input  logic [7:0]        resp_data,
  input  logic              resp_valid,
  output logic              loading,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TOT_W  = $clog2(FILE_LEN + 1);
  localparam int CH_W   = $clog2(CHUNK_LEN + 1);
  localparam logic [TOT_W-1:0]  FILE_LEN_L  = TOT_W'(FILE_LEN);
  localparam logic [CH_W-1:0]   CHUNK_LEN_L = CH_W'(CHUNK_LEN);
  localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(BYTES - 1);
  localparam logic [ADDR_W:0]   DEPTH_L     = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t              state_reg, state_next;
  logic [31:0]         offset_reg;
  logic [TOT_W-1:0]    total_reg;
  logic [CH_W-1:0]     chunk_reg;
  logic [LANE_W-1:0]   lane_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   word_reg;
  logic [DATA_W-1:0]   word_asm;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [TOT_W-1:0] total_inc;
  logic [CH_W-1:0]  chunk_inc;
  logic             byte_take;
  logic             word_write;
  logic             start_take;

  assign total_inc  = total_reg + 1'b1;
  assign chunk_inc  = chunk_reg + 1'b1;
  assign byte_take  = (state_reg == RECV) && resp_valid;
  assign word_write = byte_take && (lane_reg == LAST_LANE);
  assign start_take = ((state_reg == IDLE) || (state_reg == DONE)) && start;

  // Incoming byte lands in its lane; the other lanes keep the bytes gathered so far.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign word_asm[8*gi +: 8] = (lane_reg == LANE_W'(gi)) ? resp_data : word_reg[8*gi +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = REQ;
      REQ:        if (req_ready) state_next = RECV;
      RECV: begin
        if (resp_valid) begin
          if (total_inc == FILE_LEN_L)       state_next = DONE;
          else if (chunk_inc == CHUNK_LEN_L) state_next = REQ;
        end
      end
      default:    state_next = IDLE;
    endcase
  end

  assign req_valid  = (state_reg == REQ);
  assign loading    = (state_reg == REQ) || (state_reg == RECV);
  assign done       = (state_reg == DONE);
  assign req_offset = offset_reg;

  // offset_reg tracks base + chunk_idx*CHUNK_LEN incrementally, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_reg <= '0;
      total_reg  <= '0;
      chunk_reg  <= '0;
      lane_reg   <= '0;
      addr_reg   <= '0;
      word_reg   <= '0;
    end else if (start_take) begin
      offset_reg <= base_offset;
      total_reg  <= '0;
      chunk_reg  <= '0;
      lane_reg   <= '0;
      addr_reg   <= '0;
    end else if (byte_take) begin
      total_reg <= total_inc;
      word_reg  <= word_asm;
      lane_reg  <= (lane_reg == LAST_LANE) ? '0 : lane_reg + 1'b1;
      if (word_write) addr_reg <= addr_reg + 1'b1;
      if ((chunk_inc == CHUNK_LEN_L) && (total_inc != FILE_LEN_L)) begin
        chunk_reg  <= '0;
        offset_reg <= offset_reg + 32'(CHUNK_LEN);
      end else begin
        chunk_reg <= chunk_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_write) mem[addr_reg] <= word_asm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rd_data <= '0;
    else if (state_reg == DONE) rd_data <= ({1'b0, rd_addr} < DEPTH_L) ? mem[rd_addr] : '0;
  end

endmodule
